clk_gen_tune_ctrl: RTL and testbench
====================================

CLK_GEN_TUNE_CTRL -- requirements
Module: clk_gen_tune_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_TAPS, default 9: the number of selectable ring-delay taps (tap 0..NUM_TAPS-1).
REQ-002 The block SHALL have parameter STOP_CYCLES, default 8: the number of clk cycles the ring is held disabled before the tap switches.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 16: the number of clk cycles after ring re-enable before the lock indication.
REQ-004 The block SHALL have port clk  input  1: the single reference clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 The block SHALL have port cfg_valid_i  input  1: a configuration request is present.
REQ-007 The block SHALL have port cfg_ready_o  output  1: the block can accept a request.
REQ-008 The block SHALL have port cfg_tap_i  input  4: the requested tap index.
REQ-009 The block SHALL have port cfg_en_i  input  1: 1 = run the ring after the switch, 0 = leave it stopped.
REQ-010 The block SHALL have port ring_en_o  output  1: the oscillator loop enable (gates the ring feedback).
REQ-011 The block SHALL have port tap_sel_o  output  4: the delay-tap mux select.
REQ-012 The block SHALL have port locked_o  output  1: the ring is running and settled on tap_sel_o.
REQ-013 The block SHALL have port err_o  output  1: a one-cycle pulse when a request is rejected (see Configuration).

Function
REQ-014 A request SHALL be accepted on the rising edge where cfg_valid_i=1 and cfg_ready_o=1; the tap and enable are captured at that edge.
REQ-015 The FSM SHALL have the states IDLE, STOP, SWITCH, START and RUN.
REQ-016 cfg_ready_o SHALL be 1 only in IDLE and RUN; requests are held off in all other states.
REQ-017 IDLE: ring_en_o=0 and locked_o=0; an accept SHALL transition to SWITCH (no STOP, because the ring is already off).
REQ-018 RUN: ring_en_o=1 and locked_o=1; an accept with tap!=tap_sel_o or cfg_en_i=0 SHALL transition to STOP; locked_o SHALL fall on the accept edge.
REQ-019 RUN: an accept with tap==tap_sel_o and cfg_en_i=1 SHALL be a no-op (state, outputs and lock unchanged).
REQ-020 STOP: ring_en_o=0 for exactly STOP_CYCLES cycles, then the FSM SHALL go to SWITCH.
REQ-021 SWITCH: lasts one cycle, loads tap_sel_o with the captured tap, then goes to START if the captured enable is 1, else to IDLE.
REQ-022 START: ring_en_o=1 for exactly SETTLE_CYCLES cycles with locked_o=0, then the FSM SHALL go to RUN.
REQ-023 Invariant: tap_sel_o SHALL change only while ring_en_o=0, and only in SWITCH.
REQ-024 Latency from IDLE with enable: locked_o SHALL rise 1+SETTLE_CYCLES cycles after the accept edge.
REQ-025 Latency from RUN with enable: locked_o SHALL rise STOP_CYCLES+1+SETTLE_CYCLES cycles after the accept edge.
REQ-026 A single settle counter, wide enough for max(STOP_CYCLES,SETTLE_CYCLES), SHALL be reloaded on every state entry and SHALL NOT wrap.

Reset
REQ-027 While rst_n=0 (asynchronous): state=IDLE, ring_en_o=0, tap_sel_o=0, locked_o=0, err_o=0, cfg_ready_o=1, counter=0.
REQ-028 A reset asserted mid-sequence (STOP/SWITCH/START/RUN) SHALL drop ring_en_o immediately, without waiting for clk, and discard the pending request.

Configuration
REQ-029 With macro CLK_GEN_TUNE_RANGE_CHECK_EN defined, an accepted request with cfg_tap_i>=NUM_TAPS SHALL be rejected: no state or output change except err_o=1 for one cycle.
REQ-030 Without CLK_GEN_TUNE_RANGE_CHECK_EN, an out-of-range tap SHALL be clamped to NUM_TAPS-1 and processed normally; err_o is tied 0.

Verification
REQ-031 Reset release, then tap=3, en=1 from IDLE -> tap_sel_o=3 one cycle after accept; ring_en_o=1 next; locked_o=1 exactly 17 cycles after accept.
REQ-032 In RUN on tap 3, request tap=7, en=1 -> locked_o=0 and ring_en_o=0 for 8 cycles; tap_sel_o=7 while ring_en_o=0; locked_o=1 25 cycles after accept.
REQ-033 In RUN on tap 7, request tap=7, en=1 -> no change: ring_en_o, locked_o and cfg_ready_o stay 1 continuously.
REQ-034 In RUN, request tap=2, en=0 -> 8 cycles stopped, tap_sel_o=2, IDLE with ring_en_o=0 and cfg_ready_o=1.
REQ-035 Request tap=12 -> with the macro: err_o pulses once and the state is unchanged; without the macro: tap_sel_o=8.
REQ-036 rst_n dropped in cycle 5 of START -> ring_en_o=0 asynchronously, all outputs at reset values, cfg_ready_o=1.

Source files
------------

// File: rtl/clk_gen_tune_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_gen_tune_ctrl                                          |
// | Description : Tuning controller for a tapped ring oscillator. Accepts a  |
// |               tap/enable request, stops the ring, switches the delay-tap |
// |               mux while the ring is off, restarts it and reports lock    |
// |               after a settle interval.                                   |
// | Ports       : clk          - reference clock, rising edge               |
// |               rst_n        - asynchronous active-low reset              |
// |               cfg_valid_i  - request present                            |
// |               cfg_ready_o  - request can be accepted (IDLE or RUN)      |
// |               cfg_tap_i    - requested tap index                        |
// |               cfg_en_i     - run the ring after the switch              |
// |               ring_en_o    - oscillator loop enable                     |
// |               tap_sel_o    - delay-tap mux select                       |
// |               locked_o     - ring running and settled                   |
// |               err_o        - one-cycle pulse on a rejected request      |
// | Option      : CLK_GEN_TUNE_RANGE_CHECK_EN - reject taps >= NUM_TAPS;     |
// |               when undefined such taps clamp to NUM_TAPS-1.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module clk_gen_tune_ctrl #(
   parameter int NUM_TAPS      = 9,
   parameter int STOP_CYCLES   = 8,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_valid_i,
   output logic       cfg_ready_o,
   input  logic [3:0] cfg_tap_i,
   input  logic       cfg_en_i,
   output logic       ring_en_o,
   output logic [3:0] tap_sel_o,
   output logic       locked_o,
   output logic       err_o
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_STOP   = 3'd1;
   localparam logic [2:0] ST_SWITCH = 3'd2;
   localparam logic [2:0] ST_START  = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;

   localparam int CNT_MAX = (STOP_CYCLES > SETTLE_CYCLES) ? STOP_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Counter is loaded with N-1 on entry so the state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] STOP_LOAD   = CNT_W'(STOP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [4:0]       TAP_LIMIT   = 5'(NUM_TAPS);
   localparam logic [3:0]       TAP_LAST    = 4'(NUM_TAPS - 1);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [3:0]       pend_tap;
   logic [3:0]       pend_tap_nxt;
   logic             pend_en;
   logic             pend_en_nxt;
   logic [3:0]       tap_nxt;
   logic             accept;
   logic             tap_oor;
   logic             reject;
   logic [3:0]       req_tap;

   assign accept  = cfg_valid_i & cfg_ready_o;
   assign tap_oor = ({1'b0, cfg_tap_i} >= TAP_LIMIT);

`ifdef CLK_GEN_TUNE_RANGE_CHECK_EN
   assign reject  = tap_oor;
   assign req_tap = cfg_tap_i;
`else
   assign reject  = 1'b0;
   assign req_tap = tap_oor ? TAP_LAST : cfg_tap_i;
`endif

   // Outputs decode straight from the state register so that an asynchronous
   // reset drops the ring enable without waiting for a clock edge.
   assign ring_en_o   = (state == ST_START) || (state == ST_RUN);
   assign locked_o    = (state == ST_RUN);
   assign cfg_ready_o = (state == ST_IDLE) || (state == ST_RUN);

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = (cnt != '0) ? (cnt - CNT_W'(1)) : cnt;
      pend_tap_nxt = pend_tap;
      pend_en_nxt  = pend_en;
      tap_nxt      = tap_sel_o;

      case (state)
         ST_IDLE: begin
            // Ring is already off: go straight to the switch.  The tap is
            // loaded on the edge entering SWITCH, so it is stable for the
            // whole SWITCH cycle with the ring still disabled.
            if (accept && !reject) begin
               pend_tap_nxt = req_tap;
               pend_en_nxt  = cfg_en_i;
               tap_nxt      = req_tap;
               state_nxt    = ST_SWITCH;
               cnt_nxt      = '0;
            end
         end
         ST_RUN: begin
            // Same tap with enable set is a no-op; anything else re-tunes.
            if (accept && !reject && ((req_tap != tap_sel_o) || !cfg_en_i)) begin
               pend_tap_nxt = req_tap;
               pend_en_nxt  = cfg_en_i;
               state_nxt    = ST_STOP;
               cnt_nxt      = STOP_LOAD;
            end
         end
         ST_STOP: begin
            if (cnt == '0) begin
               tap_nxt   = pend_tap;
               state_nxt = ST_SWITCH;
               cnt_nxt   = '0;
            end
         end
         ST_SWITCH: begin
            if (pend_en) begin
               state_nxt = ST_START;
               cnt_nxt   = SETTLE_LOAD;
            end else begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         end
         ST_START: begin
            if (cnt == '0) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         tap_sel_o <= '0;
         pend_tap  <= '0;
         pend_en   <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         tap_sel_o <= tap_nxt;
         pend_tap  <= pend_tap_nxt;
         pend_en   <= pend_en_nxt;
         err_o     <= accept & reject;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_tune_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_clk_gen_tune_ctrl                                       |
// | Description : Self-checking bench for clk_gen_tune_ctrl. A timeline      |
// |               model predicts every output from the accept cycle of the   |
// |               last request; directed requests pin key instants.          |
// | Option      : CLK_GEN_TUNE_RANGE_CHECK_EN selects the reject behaviour.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_clk_gen_tune_ctrl;

   localparam int NUM_TAPS      = 9;
   localparam int STOP_CYCLES   = 8;
   localparam int SETTLE_CYCLES = 16;

   logic       clk;
   logic       rst_n;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [3:0] cfg_tap;
   logic       cfg_en;
   logic       ring_en;
   logic [3:0] tap_sel;
   logic       locked;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;

   clk_gen_tune_ctrl #(
      .NUM_TAPS      (NUM_TAPS),
      .STOP_CYCLES   (STOP_CYCLES),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_tap_i   (cfg_tap),
      .cfg_en_i    (cfg_en),
      .ring_en_o   (ring_en),
      .tap_sel_o   (tap_sel),
      .locked_o    (locked),
      .err_o       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Timeline model: a stable condition (idle/run on a tap) plus at most
   // one transition in flight, described by its accept cycle.  Relative
   // to the accept edge (d=0 just after it): d<so stopped on old tap,
   // d==so switch cycle on new tap, then settling, then running.
   // ------------------------------------------------------------------
   int       cyc;
   bit       m_run;
   bit [3:0] m_tap;
   bit       m_busy;
   int       m_ac;
   int       m_so;
   bit [3:0] m_new_tap;
   bit       m_new_en;
   int       m_err_at;

   task automatic model_reset();
      m_run    = 1'b0;
      m_tap    = 4'd0;
      m_busy   = 1'b0;
      m_ac     = 0;
      m_so     = 0;
      m_err_at = -1;
   endtask

   task automatic fold();
      int d;
      int dur;
      d   = cyc - m_ac;
      dur = m_new_en ? (m_so + 1 + SETTLE_CYCLES) : (m_so + 1);
      if (m_busy && d >= dur) begin
         m_busy = 1'b0;
         m_run  = m_new_en;
         m_tap  = m_new_tap;
      end
   endtask

   task automatic expect_now(output bit e_ring, output bit e_lock,
                             output bit e_ready, output bit [3:0] e_tap);
      int d;
      fold();
      d = cyc - m_ac;
      if (!m_busy) begin
         e_ring = m_run; e_lock = m_run; e_ready = 1'b1; e_tap = m_tap;
      end else if (d < m_so) begin
         e_ring = 1'b0; e_lock = 1'b0; e_ready = 1'b0; e_tap = m_tap;
      end else if (d == m_so) begin
         e_ring = 1'b0; e_lock = 1'b0; e_ready = 1'b0; e_tap = m_new_tap;
      end else begin
         e_ring = 1'b1; e_lock = 1'b0; e_ready = 1'b0; e_tap = m_new_tap;
      end
   endtask

   task automatic model_accept();
      int  t;
      bit  oor;
      t   = int'(cfg_tap);
      oor = (t >= NUM_TAPS);
`ifdef CLK_GEN_TUNE_RANGE_CHECK_EN
      if (oor) begin
         m_err_at = cyc;
         return;
      end
`else
      if (oor) t = NUM_TAPS - 1;
`endif
      if (m_run && t == int'(m_tap) && cfg_en) return;
      m_busy    = 1'b1;
      m_ac      = cyc;
      m_so      = m_run ? STOP_CYCLES : 0;
      m_new_tap = 4'(t);
      m_new_en  = cfg_en;
   endtask

   task automatic compare_all();
      bit       e_ring, e_lock, e_ready;
      bit [3:0] e_tap;
      expect_now(e_ring, e_lock, e_ready, e_tap);
      chk("ring_en_o",   32'(ring_en),   32'(e_ring));
      chk("locked_o",    32'(locked),    32'(e_lock));
      chk("cfg_ready_o", 32'(cfg_ready), 32'(e_ready));
      chk("tap_sel_o",   32'(tap_sel),   32'(e_tap));
      chk("err_o",       32'(err),       32'(cyc == m_err_at));
   endtask

   // Model update on rising edges, comparison on falling edges, and an
   // immediate check just after reset assertion.
   initial begin
      bit       p_ring, p_lock, p_ready;
      bit [3:0] p_tap;
      cyc = 0;
      model_reset();
      forever begin
         @(posedge clk or negedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
            if (!clk || $time == 0) begin
               #1;
               compare_all();
            end
         end else if (clk) begin
            expect_now(p_ring, p_lock, p_ready, p_tap);
            cyc++;
            if (cfg_valid && p_ready) model_accept();
         end else begin
            compare_all();
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus with hand-computed pins
   // ------------------------------------------------------------------
   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the falling edge just after the accept edge (d=0).
   task automatic req(input logic [3:0] t, input logic en);
      @(negedge clk);
      #1;
      cfg_valid = 1'b1;
      cfg_tap   = t;
      cfg_en    = en;
      @(negedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   initial begin
      int start_d;
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_tap   = 4'd0;
      cfg_en    = 1'b0;
      adv(2);
      chk("pin_reset_ready", 32'(cfg_ready), 32'd1);
      chk("pin_reset_ring",  32'(ring_en),   32'd0);
      #1 rst_n = 1'b1;

      // From IDLE: tap 3 enabled, lock 17 cycles after accept
      req(4'd3, 1'b1);
      chk("pin_idle_tap",   32'(tap_sel), 32'd3);
      chk("pin_idle_ring0", 32'(ring_en), 32'd0);
      adv(1);
      chk("pin_idle_ring1", 32'(ring_en), 32'd1);
      adv(15);
      chk("pin_idle_lock16", 32'(locked), 32'd0);
      adv(1);
      chk("pin_idle_lock17", 32'(locked), 32'd1);

      // RUN tap 3 -> tap 7; a request during STOP must be held off
      req(4'd7, 1'b1);
      chk("pin_retune_lock0", 32'(locked), 32'd0);
      chk("pin_retune_ring0", 32'(ring_en), 32'd0);
      adv(3);
      cfg_valid = 1'b1;
      cfg_tap   = 4'd1;
      cfg_en    = 1'b1;
      adv(2);
      cfg_valid = 1'b0;
      adv(2);
      chk("pin_retune_tap_d7", 32'(tap_sel), 32'd3);
      adv(1);
      chk("pin_retune_tap_d8",  32'(tap_sel), 32'd7);
      chk("pin_retune_ring_d8", 32'(ring_en), 32'd0);
      adv(1);
      chk("pin_retune_ring_d9", 32'(ring_en), 32'd1);
      adv(15);
      chk("pin_retune_lock24", 32'(locked), 32'd0);
      adv(1);
      chk("pin_retune_lock25", 32'(locked), 32'd1);

      // RUN tap 7, same request: no-op
      req(4'd7, 1'b1);
      chk("pin_noop_lock",  32'(locked),    32'd1);
      chk("pin_noop_ready", 32'(cfg_ready), 32'd1);
      adv(5);
      chk("pin_noop_ring", 32'(ring_en), 32'd1);

      // RUN -> stop on tap 2, end in IDLE
      req(4'd2, 1'b0);
      adv(8);
      chk("pin_stop_tap",   32'(tap_sel),   32'd2);
      chk("pin_stop_ready", 32'(cfg_ready), 32'd0);
      adv(1);
      chk("pin_stop_idle_ready", 32'(cfg_ready), 32'd1);
      chk("pin_stop_idle_ring",  32'(ring_en),   32'd0);

      // Out-of-range tap 12 from IDLE
      req(4'd12, 1'b1);
`ifdef CLK_GEN_TUNE_RANGE_CHECK_EN
      chk("pin_oor_err",   32'(err),       32'd1);
      chk("pin_oor_tap",   32'(tap_sel),   32'd2);
      chk("pin_oor_ready", 32'(cfg_ready), 32'd1);
      adv(1);
      chk("pin_oor_err_gone", 32'(err), 32'd0);
      start_d = 5;
`else
      chk("pin_oor_tap", 32'(tap_sel), 32'd8);
      chk("pin_oor_err", 32'(err),     32'd0);
      adv(17);
      chk("pin_oor_lock", 32'(locked), 32'd1);
      start_d = STOP_CYCLES + 1 + 4;
`endif

      // Reset in the fifth cycle of START
      req(4'd5, 1'b1);
      adv(start_d);
      chk("pin_start_ring", 32'(ring_en), 32'd1);
      chk("pin_start_lock", 32'(locked),  32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("pin_async_ring",  32'(ring_en),   32'd0);
      chk("pin_async_ready", 32'(cfg_ready), 32'd1);
      chk("pin_async_tap",   32'(tap_sel),   32'd0);
      chk("pin_async_lock",  32'(locked),    32'd0);
      chk("pin_async_err",   32'(err),       32'd0);
      adv(2);
      #1 rst_n = 1'b1;
      adv(2);
      chk("pin_after_rst_tap", 32'(tap_sel), 32'd0);

      // Fresh request after reset proves the earlier one was discarded
      req(4'd4, 1'b1);
      chk("pin_post_tap", 32'(tap_sel), 32'd4);
      adv(17);
      chk("pin_post_lock", 32'(locked), 32'd1);
      adv(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
